timer_irq_ctrl: RTL and testbench

TIMER_IRQ_CTRL -- requirements
Module: timer_irq_ctrl

---
 rtl/timer_irq_pkg.sv | 11 +
 rtl/edge_detect_rise.sv | 23 ++
 rtl/timer_irq_ctrl.sv | 139 +++++++++++++
 tb/tb_timer_irq_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_irq_pkg.sv
// Shared constants for the PicoBlaze timer interrupt controller: FSM encodings
// and the default width of the missed-event counter.
package timer_irq_pkg;

    localparam int MISS_W_DEFAULT = 8;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_PEND = 2'b10;

endpackage

// File: rtl/edge_detect_rise.sv
// Rising-edge detector. The history register resets to 1 so that a level that
// is already high when reset releases is not mistaken for a fresh edge.
module edge_detect_rise (
    input  logic clk_in,
    input  logic rst_n,
    input  logic sig_i,
    output logic rise_o
);

    logic sig_q;

    // one-cycle history of the monitored level
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= 1'b1;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/timer_irq_ctrl.sv
// Timer interrupt controller for PicoBlaze: restarts the timer, raises and
// holds the interrupt until acknowledged. Optional miss counter: TIMER_IRQ_MISS_CNT_EN.
module timer_irq_ctrl
    import timer_irq_pkg::*;
#(
    parameter int MISS_W = MISS_W_DEFAULT
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              tmr_int,
    input  logic              start,
    input  logic              enable,
    input  logic              auto_rearm,
    input  logic              interrupt_ack,
    input  logic              clear_miss,
    output logic              go,
    output logic              interrupt,
    output logic              pending,
    output logic [MISS_W-1:0] miss_cnt
);

    logic       evt_s;
    logic       want_go_s;
    logic [1:0] state_q, state_d;
    logic       go_q, go_d;
    logic       irq_q, irq_d;
    logic       pend_q, pend_d;

    edge_detect_rise u_edge (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .sig_i  (tmr_int),
        .rise_o (evt_s)
    );

    // next state; a timer event outranks a coincident start request
    always_comb begin
        state_d   = state_q;
        want_go_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_RUN;
                    want_go_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (evt_s) begin
                    if (enable) begin
                        state_d = ST_PEND;
                    end else if (auto_rearm) begin
                        want_go_s = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (start) begin
                    want_go_s = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_PEND: begin
                if (interrupt_ack) begin
                    if (auto_rearm) begin
                        state_d   = ST_RUN;
                        want_go_s = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_PEND;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // a restart requested right after a go pulse is dropped so go stays single-cycle
        go_d   = want_go_s & ~go_q;
        irq_d  = (state_d == ST_PEND);
        pend_d = (state_d == ST_PEND);
    end

    // FSM and registered outputs
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            go_q    <= 1'b0;
            irq_q   <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            go_q    <= go_d;
            irq_q   <= irq_d;
            pend_q  <= pend_d;
        end
    end

    assign go        = go_q;
    assign interrupt = irq_q;
    assign pending   = pend_q;

`ifdef TIMER_IRQ_MISS_CNT_EN
    localparam logic [MISS_W-1:0] MISS_ONE = {{(MISS_W-1){1'b0}}, 1'b1};

    logic [MISS_W-1:0] miss_q, miss_d;

    // saturating count of events lost while pending; clear has priority
    always_comb begin
        miss_d = miss_q;
        if (clear_miss) begin
            miss_d = '0;
        end else if ((state_q == ST_PEND) && evt_s && (miss_q != {MISS_W{1'b1}})) begin
            miss_d = miss_q + MISS_ONE;
        end else begin
            miss_d = miss_q;
        end
    end

    // miss counter register
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            miss_q <= '0;
        end else begin
            miss_q <= miss_d;
        end
    end

    assign miss_cnt = miss_q;
`else
    logic unused_clear_miss;

    assign unused_clear_miss = clear_miss;
    assign miss_cnt          = '0;
`endif

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Self-checking bench for timer_irq_ctrl: directed vector table, hand-written
// corner sequences and a randomized run against a behavioural model.
module tb_timer_irq_ctrl;

`ifdef TIMER_IRQ_MISS_CNT_EN
    localparam bit MISS_ON = 1'b1;
`else
    localparam bit MISS_ON = 1'b0;
`endif
    localparam int MISS_MAX = 255;
    localparam int M_IDLE = 0, M_RUN = 1, M_PEND = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tmr_int, start, enable, auto_rearm, interrupt_ack, clear_miss;
    logic       go, interrupt, pending;
    logic [7:0] miss_cnt;

    int n_total = 0;
    int n_pass  = 0;

    // behavioural model state
    int m_st, m_miss;
    bit m_prev, m_go;

    typedef struct {
        logic s, en, ar, t, a, c;
        logic g, i, p;
        int   miss;
    } vec_t;

    vec_t tbl[21];

    timer_irq_ctrl #(.MISS_W(8)) dut (
        .clk_in        (clk),
        .rst_n         (rst_n),
        .tmr_int       (tmr_int),
        .start         (start),
        .enable        (enable),
        .auto_rearm    (auto_rearm),
        .interrupt_ack (interrupt_ack),
        .clear_miss    (clear_miss),
        .go            (go),
        .interrupt     (interrupt),
        .pending       (pending),
        .miss_cnt      (miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic int exp_miss(input int m);
        return MISS_ON ? m : 0;
    endfunction

    // Spec rules applied to one clock edge with the given inputs.
    task automatic model_edge(input bit s, en, ar, t, a, c);
        bit ev, want;
        int nst;
        ev   = t && !m_prev;
        want = 1'b0;
        nst  = m_st;
        if (m_st == M_IDLE) begin
            if (s) begin want = 1'b1; nst = M_RUN; end
        end else if (m_st == M_RUN) begin
            if (ev) begin
                if (en)      nst = M_PEND;
                else if (ar) want = 1'b1;
                else         nst = M_IDLE;
            end else if (s) begin
                want = 1'b1;
            end
        end else begin
            if (a) begin nst = ar ? M_RUN : M_IDLE; want = ar; end
        end
        if (MISS_ON) begin
            if (c) m_miss = 0;
            else if (m_st == M_PEND && ev && m_miss < MISS_MAX) m_miss = m_miss + 1;
        end
        m_go   = want && !m_go;
        m_st   = nst;
        m_prev = t;
    endtask

    task automatic step(input logic s, en, ar, t, a, c);
        start = s; enable = en; auto_rearm = ar; tmr_int = t;
        interrupt_ack = a; clear_miss = c;
        @(posedge clk);
        model_edge(s, en, ar, t, a, c);
        #1;
    endtask

    task automatic do_reset(input logic t);
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0; enable = 1'b0; auto_rearm = 1'b0; tmr_int = t;
        interrupt_ack = 1'b0; clear_miss = 1'b0;
        #1;
        chk("rst_go", go, 0);
        chk("rst_irq", interrupt, 0);
        chk("rst_pend", pending, 0);
        chk("rst_miss", miss_cnt, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_st = M_IDLE; m_miss = 0; m_prev = 1'b1; m_go = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1;
        tbl[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 0};
        tbl[1]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0, 0};
        tbl[2]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 0};
        tbl[3]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0, 0};
        tbl[4]  = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b1,1'b1, 0};
        tbl[5]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b1,1'b1, 0};
        tbl[6]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b1, 0};
        tbl[7]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b1,1'b1, 1};
        tbl[8]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0, 1};
        tbl[9]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0, 1};
        tbl[10] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0, 0};
        tbl[11] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0, 0};
        tbl[12] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 0};
        tbl[13] = '{1'b0,1'b0,1'b1,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0, 0};
        tbl[14] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 0};
        tbl[15] = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0, 0};
        tbl[16] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0, 0};
        tbl[17] = '{1'b1,1'b1,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b1,1'b1, 0};
        tbl[18] = '{1'b0,1'b0,1'b1,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b0, 0};
        tbl[19] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 0};
        tbl[20] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0, 0};

        // directed vector table
        do_reset(1'b0);
        for (int k = 0; k < 21; k++) begin
            step(tbl[k].s, tbl[k].en, tbl[k].ar, tbl[k].t, tbl[k].a, tbl[k].c);
            chk($sformatf("tbl%0d_go", k), go, tbl[k].g);
            chk($sformatf("tbl%0d_irq", k), interrupt, tbl[k].i);
            chk($sformatf("tbl%0d_pend", k), pending, tbl[k].p);
            chk($sformatf("tbl%0d_miss", k), miss_cnt, exp_miss(tbl[k].miss));
        end

        // tmr_int already high at reset release: no spurious event
        do_reset(1'b1);
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
            chk("hi_rst_irq", interrupt, 0);
            chk("hi_rst_go", go, 0);
        end
        chk("hi_rst_miss", miss_cnt, 0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("hi_rst_idle_start_go", go, 1);

        // start, event, ack timing with auto rearm
        do_reset(1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("seq_pre_irq", interrupt, 0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("seq_irq_rise", interrupt, 1);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("seq_irq_held_en0", interrupt, 1);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("seq_ack_irq", interrupt, 0);
        chk("seq_ack_go", go, 1);
        chk("seq_ack_pend", pending, 0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("seq_go_single", go, 0);
        chk("seq_run_no_irq", interrupt, 0);

        // saturation with 300 events while pending, then clear
        do_reset(1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 255; k++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        chk("sat_255", miss_cnt, exp_miss(255));
        for (int k = 0; k < 45; k++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        chk("sat_no_wrap", miss_cnt, exp_miss(255));
        chk("sat_still_pend", pending, 1);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("clear_miss", miss_cnt, 0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("miss_after_clear", miss_cnt, exp_miss(1));
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("clear_beats_inc", miss_cnt, 0);

        // event coincident with ack counts as a miss
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("evt_ack_miss", miss_cnt, exp_miss(1));
        chk("evt_ack_leave", pending, 0);
        chk("evt_ack_go", go, 0);

        // reset mid-pend drops interrupt immediately
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("pre_rst_irq", interrupt, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_irq", interrupt, 0);
        chk("mid_rst_pend", pending, 0);
        chk("mid_rst_miss", miss_cnt, 0);

        // randomized run against the model
        do_reset(1'b0);
        for (int k = 0; k < 3000; k++) begin
            logic s, en, ar, t, a, c;
            s  = ($urandom_range(0, 5) == 0);
            en = ($urandom_range(0, 3) != 0);
            ar = $urandom_range(0, 1) == 1;
            t  = ($urandom_range(0, 2) == 0) ? ~tmr_int : tmr_int;
            a  = ($urandom_range(0, 5) == 0);
            c  = ($urandom_range(0, 63) == 0);
            step(s, en, ar, t, a, c);
            chk("rnd_go", go, m_go);
            chk("rnd_irq", interrupt, m_st == M_PEND);
            chk("rnd_pend", pending, m_st == M_PEND);
            chk("rnd_miss", miss_cnt, m_miss);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
